servile_wb_arbiter_n: RTL and testbench

// - N-master to 1-slave Wishbone arbiter for Servile-class SoCs. It generalises the fixed
//   2-port ibus/dbus arbiter to a parametrised master count.
// - Arbitration mode is selectable: fixed priority or round-robin.
// - Optional bus-timeout watchdog that error-terminates a hung transfer.
// - Sits between the CPU/DMA/debug masters and the memory Wishbone port.

---
 rtl/servile_wb_arbiter_n.sv | 139 +++++++++++++
 tb/tb_servile_wb_arbiter_n.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/servile_wb_arbiter_n.sv
// N-master to 1-slave Wishbone arbiter for Servile-class SoCs.
// Fixed-priority or round-robin arbitration, with an optional watchdog
// that error-terminates a transfer the slave never acknowledges.
module servile_wb_arbiter_n #(
  parameter int    N       = 2,
  parameter string MODE    = "RR",
  parameter int    TIMEOUT = 0,
  parameter int    GW      = ($clog2(N) > 0) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N*32-1:0] i_wb_m_adr,
  input  logic [N*32-1:0] i_wb_m_dat,
  input  logic [N*4-1:0]  i_wb_m_sel,
  input  logic [N-1:0]    i_wb_m_we,
  input  logic [N-1:0]    i_wb_m_stb,
  output logic [31:0]     o_wb_m_rdt,
  output logic [N-1:0]    o_wb_m_ack,
  output logic [N-1:0]    o_wb_m_err,
  output logic [31:0]     o_wb_s_adr,
  output logic [31:0]     o_wb_s_dat,
  output logic [3:0]      o_wb_s_sel,
  output logic            o_wb_s_we,
  output logic            o_wb_s_stb,
  input  logic [31:0]     i_wb_s_rdt,
  input  logic            i_wb_s_ack,
  output logic [N-1:0]    o_grant
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam bit FIXED = (MODE == "FIXED");
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  logic [0:0]    state;
  logic [N-1:0]  grant;
  logic [GW-1:0] last;
  logic [GW-1:0] owner;
  logic [GW-1:0] winner;
  logic [TW-1:0] count;
  logic          busy;
  logic          owner_stb;
  logic          to_hit;
  logic          done;

  assign busy      = (state == ST_BUSY);
  assign owner_stb = busy & |(grant & i_wb_m_stb);
  assign to_hit    = (TIMEOUT > 0) && busy && (count == TO_LAST) && !i_wb_s_ack;
  assign done      = busy & (i_wb_s_ack | ~owner_stb | to_hit);

  assign o_grant    = grant;
  assign o_wb_m_rdt = i_wb_s_rdt;
  assign o_wb_m_ack = grant & {N{busy & i_wb_s_ack}};
  assign o_wb_m_err = grant & {N{to_hit}};
  assign o_wb_s_stb = owner_stb & ~to_hit;

  // Binary index of the current one-hot owner, used to record who was last served.
  always_comb begin
    owner = '0;
    for (int k = 0; k < N; k++) begin
      if (grant[k]) owner = GW'(k);
    end
  end

  // Pick the next owner: lowest requester, or first requester after the last owner.
  always_comb begin
    logic found;
    int   idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    if (FIXED) begin
      for (int k = 0; k < N; k++) begin
        if (!found && i_wb_m_stb[k]) begin
          winner = GW'(k);
          found  = 1'b1;
        end
      end
    end else begin
      for (int i = 1; i <= N; i++) begin
        idx = (int'(last) + i) % N;
        if (!found && i_wb_m_stb[idx]) begin
          winner = GW'(idx);
          found  = 1'b1;
        end
      end
    end
  end

  // AND-OR one-hot mux steering the owner's request onto the slave port.
  always_comb begin
    o_wb_s_adr = '0;
    o_wb_s_dat = '0;
    o_wb_s_sel = '0;
    o_wb_s_we  = 1'b0;
    for (int k = 0; k < N; k++) begin
      o_wb_s_adr = o_wb_s_adr | (i_wb_m_adr[32*k +: 32] & {32{grant[k]}});
      o_wb_s_dat = o_wb_s_dat | (i_wb_m_dat[32*k +: 32] & {32{grant[k]}});
      o_wb_s_sel = o_wb_s_sel | (i_wb_m_sel[4*k +: 4] & {4{grant[k]}});
      o_wb_s_we  = o_wb_s_we  | (i_wb_m_we[k] & grant[k]);
    end
  end

  // Arbitration FSM: grant in IDLE, release on ack, abort or watchdog expiry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      grant <= '0;
      last  <= GW'(N - 1);
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|i_wb_m_stb) begin
            state <= ST_BUSY;
            grant <= N'(1) << winner;
            count <= '0;
          end
        end
        ST_BUSY: begin
          if (done) begin
            state <= ST_IDLE;
            grant <= '0;
            last  <= owner;
          end else begin
            count <= count + TW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servile_wb_arbiter_n.sv
// Self-checking bench for servile_wb_arbiter_n: a round-robin instance with
// the watchdog enabled and a fixed-priority instance, sharing clock and reset.
module tb_servile_wb_arbiter_n;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N*32-1:0] m_adr;
  logic [N*32-1:0] m_dat;
  logic [N*4-1:0]  m_sel;
  logic [N-1:0]    m_we;
  logic [N-1:0]    m_stb;
  logic [N-1:0]    fx_stb;
  logic [31:0]     s_rdt;
  logic            s_ack;
  logic            fx_ack;

  logic [31:0]  rdt, s_adr, s_dat, fx_rdt, fx_s_adr, fx_s_dat;
  logic [3:0]   s_sel, fx_s_sel;
  logic         s_we, s_stb, fx_s_we, fx_s_stb;
  logic [N-1:0] ack, err, grant, fx_ack_o, fx_err, fx_grant;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  // Free-running clock shared by both instances.
  always #5 clk = ~clk;

  servile_wb_arbiter_n #(.N(N), .MODE("RR"), .TIMEOUT(8)) dut_rr (
    .i_clk(clk), .i_rst(rst),
    .i_wb_m_adr(m_adr), .i_wb_m_dat(m_dat), .i_wb_m_sel(m_sel),
    .i_wb_m_we(m_we), .i_wb_m_stb(m_stb),
    .o_wb_m_rdt(rdt), .o_wb_m_ack(ack), .o_wb_m_err(err),
    .o_wb_s_adr(s_adr), .o_wb_s_dat(s_dat), .o_wb_s_sel(s_sel),
    .o_wb_s_we(s_we), .o_wb_s_stb(s_stb),
    .i_wb_s_rdt(s_rdt), .i_wb_s_ack(s_ack), .o_grant(grant)
  );

  servile_wb_arbiter_n #(.N(N), .MODE("FIXED"), .TIMEOUT(0)) dut_fx (
    .i_clk(clk), .i_rst(rst),
    .i_wb_m_adr(m_adr), .i_wb_m_dat(m_dat), .i_wb_m_sel(m_sel),
    .i_wb_m_we(m_we), .i_wb_m_stb(fx_stb),
    .o_wb_m_rdt(fx_rdt), .o_wb_m_ack(fx_ack_o), .o_wb_m_err(fx_err),
    .o_wb_s_adr(fx_s_adr), .o_wb_s_dat(fx_s_dat), .o_wb_s_sel(fx_s_sel),
    .o_wb_s_we(fx_s_we), .o_wb_s_stb(fx_s_stb),
    .i_wb_s_rdt(s_rdt), .i_wb_s_ack(fx_ack), .o_grant(fx_grant)
  );

  function automatic int idx_of(input logic [N-1:0] g);
    int r = -1;
    int n = 0;
    for (int k = 0; k < N; k++) begin
      if (g[k] === 1'b1) begin
        r = k;
        n++;
      end
    end
    if (n != 1) r = -1;
    return r;
  endfunction

  task automatic wait_grant(input bit use_fx, output int g);
    g = -1;
    for (int c = 0; c < 20; c++) begin
      if (use_fx ? (fx_grant != '0) : (grant != '0)) begin
        g = idx_of(use_fx ? fx_grant : grant);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int g, e;
    rst = 1'b1; m_stb = 4'b1111; fx_stb = '0; s_ack = 1'b0; fx_ack = 1'b0; s_rdt = '0;
    for (int k = 0; k < N; k++) begin
      m_adr[32*k +: 32] = 32'hA000_0000 | 32'(k);
      m_dat[32*k +: 32] = 32'h5500_0000 | 32'(k);
      m_sel[4*k +: 4]   = 4'(k + 1);
    end
    m_we = 4'b0101;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({grant, s_stb, ack, err, fx_grant, fx_s_stb} !== '0)
        begin errors++; $display("[TB] FAIL reset_during: grant=%b stb=%b ack=%b err=%b required all 0", grant, s_stb, ack, err); end
    end
    rst = 1'b0; m_stb = '0;
    @(negedge clk);
    checks++;
    if ({grant, s_stb, ack, err} !== '0)
      begin errors++; $display("[TB] FAIL reset_after: grant=%b stb=%b ack=%b err=%b required all 0", grant, s_stb, ack, err); end
    m_stb = 4'b0100; exp_q.push_back(2);
    @(negedge clk);
    g = idx_of(grant); e = exp_q.pop_front();
    checks++;
    if (grant !== 4'b0100 || g != e)
      begin errors++; $display("[TB] FAIL reset_first_grant: grant=%b required 0100", grant); end
    checks++;
    if (s_stb !== 1'b1 || s_adr !== 32'hA000_0002 || s_sel !== 4'h3 || s_we !== 1'b1)
      begin errors++; $display("[TB] FAIL reset_slave_follow: stb=%b adr=%h sel=%h we=%b required 1 a0000002 3 1", s_stb, s_adr, s_sel, s_we); end
    s_ack = 1'b1; #1;
    checks++;
    if (ack !== 4'b0100)
      begin errors++; $display("[TB] FAIL reset_ack: ack=%b required 0100", ack); end
    @(negedge clk);
    s_ack = 1'b0; m_stb = '0;
    checks++;
    if (grant !== '0)
      begin errors++; $display("[TB] FAIL reset_release: grant=%b required 0000", grant); end
  endtask

  task automatic test_rr_fairness;
    int g, e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; m_stb = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0);
    for (int t = 0; t < 5; t++) begin
      wait_grant(1'b0, g);
      e = exp_q.pop_front();
      checks++;
      if (g != e)
        begin errors++; $display("[TB] FAIL rr_order[%0d]: granted %0d required %0d", t, g, e); end
      s_ack = 1'b1; #1;
      checks++;
      if (ack !== (4'b0001 << e))
        begin errors++; $display("[TB] FAIL rr_ack[%0d]: ack=%b required %b", t, ack, 4'b0001 << e); end
      @(negedge clk);
      s_ack = 1'b0;
    end
    m_stb = '0;
  endtask

  task automatic test_data_path;
    int g, e;
    m_adr[32 +: 32] = 32'h0000_1000; m_we[1] = 1'b0;
    m_stb = 4'b0010; exp_q.push_back(1);
    wait_grant(1'b0, g);
    e = exp_q.pop_front();
    checks++;
    if (g != e)
      begin errors++; $display("[TB] FAIL data_grant: granted %0d required %0d", g, e); end
    checks++;
    if (s_adr !== 32'h0000_1000 || s_we !== 1'b0 || s_stb !== 1'b1)
      begin errors++; $display("[TB] FAIL data_slave_req: adr=%h we=%b stb=%b required 00001000 0 1", s_adr, s_we, s_stb); end
    for (int w = 0; w < 3; w++) begin
      checks++;
      if (ack !== '0 || err !== '0)
        begin errors++; $display("[TB] FAIL data_wait[%0d]: ack=%b err=%b required 0000 0000", w, ack, err); end
      @(negedge clk);
    end
    s_ack = 1'b1; s_rdt = 32'hDEADBEEF; #1;
    checks++;
    if (ack !== 4'b0010 || rdt !== 32'hDEADBEEF)
      begin errors++; $display("[TB] FAIL data_ack: ack=%b rdt=%h required 0010 deadbeef", ack, rdt); end
    @(negedge clk);
    s_ack = 1'b0; s_rdt = '0; m_stb = '0;
  endtask

  task automatic test_timeout;
    int g, e;
    logic [N-1:0] exp_err;
    m_stb = 4'b0001; exp_q.push_back(0);
    wait_grant(1'b0, g);
    e = exp_q.pop_front();
    checks++;
    if (g != e)
      begin errors++; $display("[TB] FAIL to_grant: granted %0d required %0d", g, e); end
    for (int k = 1; k <= 8; k++) begin
      exp_err = (k == 8) ? 4'b0001 : 4'b0000;
      checks++;
      if (err !== exp_err || s_stb !== (k != 8))
        begin errors++; $display("[TB] FAIL to_cycle[%0d]: err=%b stb=%b required %b %b", k, err, s_stb, exp_err, k != 8); end
      if (k < 8) @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (grant !== '0 || err !== '0)
      begin errors++; $display("[TB] FAIL to_release: grant=%b err=%b required 0000 0000", grant, err); end
    exp_q.push_back(0);
    wait_grant(1'b0, g);
    e = exp_q.pop_front();
    checks++;
    if (g != e || s_stb !== 1'b1)
      begin errors++; $display("[TB] FAIL to_regrant: granted %0d stb=%b required %0d 1", g, s_stb, e); end
    s_ack = 1'b1; #1;
    checks++;
    if (ack !== 4'b0001 || err !== '0)
      begin errors++; $display("[TB] FAIL to_regrant_ack: ack=%b err=%b required 0001 0000", ack, err); end
    @(negedge clk);
    s_ack = 1'b0; m_stb = '0;
  endtask

  task automatic test_abort_reset;
    int g, e;
    m_stb = 4'b0100; exp_q.push_back(2);
    wait_grant(1'b0, g);
    e = exp_q.pop_front();
    checks++;
    if (g != e)
      begin errors++; $display("[TB] FAIL abort_grant: granted %0d required %0d", g, e); end
    @(negedge clk);
    m_stb = '0; #1;
    checks++;
    if (s_stb !== 1'b0 || ack !== '0 || err !== '0)
      begin errors++; $display("[TB] FAIL abort_cycle: stb=%b ack=%b err=%b required 0 0000 0000", s_stb, ack, err); end
    @(negedge clk);
    checks++;
    if (grant !== '0 || ack !== '0)
      begin errors++; $display("[TB] FAIL abort_idle: grant=%b ack=%b required 0000 0000", grant, ack); end
    m_stb = 4'b1000; exp_q.push_back(3);
    wait_grant(1'b0, g);
    e = exp_q.pop_front();
    checks++;
    if (g != e)
      begin errors++; $display("[TB] FAIL midrst_grant: granted %0d required %0d", g, e); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== '0 || s_stb !== 1'b0)
      begin errors++; $display("[TB] FAIL midrst_drop: grant=%b stb=%b required 0000 0", grant, s_stb); end
    rst = 1'b0; m_stb = 4'b1111; exp_q.push_back(0);
    wait_grant(1'b0, g);
    e = exp_q.pop_front();
    checks++;
    if (g != e)
      begin errors++; $display("[TB] FAIL midrst_rr_restart: granted %0d required %0d", g, e); end
    s_ack = 1'b1;
    @(negedge clk);
    s_ack = 1'b0; m_stb = '0;
  endtask

  task automatic test_fixed_priority;
    int g, e;
    fx_stb = 4'b1010;
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(3);
    for (int t = 0; t < 4; t++) begin
      wait_grant(1'b1, g);
      e = exp_q.pop_front();
      checks++;
      if (g != e)
        begin errors++; $display("[TB] FAIL fixed_order[%0d]: granted %0d required %0d", t, g, e); end
      fx_ack = 1'b1; #1;
      checks++;
      if (fx_ack_o !== (4'b0001 << e))
        begin errors++; $display("[TB] FAIL fixed_ack[%0d]: ack=%b required %b", t, fx_ack_o, 4'b0001 << e); end
      @(negedge clk);
      fx_ack = 1'b0;
      if (t == 2) fx_stb = 4'b1000;
    end
    fx_stb = '0;
  endtask

  // Run each scenario in turn and report the totals.
  initial begin
    test_reset();
    test_rr_fairness();
    test_data_path();
    test_timeout();
    test_abort_reset();
    test_fixed_priority();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
